// File: rtl/spi_pkg.sv
// Shared types for the SPI transmit engine: FSM state encoding and SPI mode helpers.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        CAPTURE  = 3'd2,
        SHIFT    = 3'd3,
        COMPLETE = 3'd4
    } state_t;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    function automatic logic [1:0] spi_mode(input logic cpol, input logic cpha);
        return {cpol, cpha};
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: toggles sclk every CLK_DIV cycles while enabled, parks at CPOL otherwise,
// and flags which toggle is the leading or trailing edge of the SPI clock.
module spi_clk_gen #(
    parameter int CLK_DIV = 2,
    parameter bit CPOL    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic sclk_o,
    output logic lead_edge_o,
    output logic trail_edge_o
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             sclk_q, sclk_d;
    logic             wrap;

    assign wrap = en_i && (div_cnt_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        div_cnt_d = div_cnt_q;
        sclk_d    = sclk_q;
        if (!en_i) begin
            div_cnt_d = '0;
            sclk_d    = CPOL;
        end else if (wrap) begin
            div_cnt_d = '0;
            sclk_d    = ~sclk_q;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            sclk_q    <= CPOL;
        end else begin
            div_cnt_q <= div_cnt_d;
            sclk_q    <= sclk_d;
        end
    end

    // Leaving the idle level is the leading edge; returning to it is the trailing edge.
    assign lead_edge_o  = wrap && (sclk_q == CPOL);
    assign trail_edge_o = wrap && (sclk_q != CPOL);
    assign sclk_o       = sclk_q;

endmodule

// File: rtl/spi_tx_engine.sv
// FIFO-fed SPI master transmitter with configurable width, divider, CPOL/CPHA and bit order.
// Define SPI_TX_BURST_EN to send back-to-back words under a single chip select.
module spi_tx_engine
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  empty,
    input  logic                  full,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_en,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  cs_n,
    output logic                  busy,
    output logic                  done
);
    localparam int         CNT_W         = $clog2(DATA_WIDTH);
    localparam logic [1:0] MODE          = spi_mode(CPOL, CPHA);
    localparam bit         SHIFT_ON_LEAD = (MODE == SPI_MODE1) || (MODE == SPI_MODE3);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  first_q, first_d;
    logic                  mosi_q, mosi_d;
    logic                  cs_n_q, cs_n_d;
    logic                  lead_edge, trail_edge, shift_edge, fifo_ready;

    spi_clk_gen #(.CLK_DIV(CLK_DIV), .CPOL(CPOL)) u_clk_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (state_q == SHIFT),
        .sclk_o      (sclk),
        .lead_edge_o (lead_edge),
        .trail_edge_o(trail_edge)
    );

    // empty && full is an illegal FIFO status; it is treated as empty.
    assign fifo_ready = !empty && !(empty && full);

    // With CPHA=1 the first leading edge only presents bit 0; no shift after the last bit.
    assign shift_edge = (bit_cnt_q != '0) &&
                        (SHIFT_ON_LEAD ? (lead_edge && !first_q) : trail_edge);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        first_d   = first_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        unique case (state_q)
            IDLE:    if (fifo_ready) state_d = LOAD;
            LOAD:    state_d = CAPTURE;
            CAPTURE: begin
                shift_d   = read_data;
                bit_cnt_d = CNT_W'(DATA_WIDTH - 1);
                first_d   = 1'b1;
                cs_n_d    = 1'b0;
                mosi_d    = MSB_FIRST ? read_data[DATA_WIDTH-1] : read_data[0];
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (shift_edge) begin
                    shift_d   = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
                    mosi_d    = MSB_FIRST ? shift_q[DATA_WIDTH-2] : shift_q[1];
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
                if (lead_edge) first_d = 1'b0;
                if (trail_edge && bit_cnt_q == '0) state_d = COMPLETE;
            end
            COMPLETE: begin
`ifdef SPI_TX_BURST_EN
                if (fifo_ready) begin
                    state_d = LOAD;
                end else begin
                    cs_n_d  = 1'b1;
                    state_d = IDLE;
                end
`else
                cs_n_d  = 1'b1;
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            first_q   <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            first_q   <= first_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
        end
    end

    assign read_en = (state_q == LOAD);
    assign done    = (state_q == COMPLETE);
    assign busy    = (state_q != IDLE);
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;

endmodule
